// File: rtl/dffe_word_deserializer.sv
// Collects WIDTH enabled serial bits into a parallel word and holds it with a
// valid/ack handshake; a word that completes while the previous one is still held is dropped.
module dffe_word_deserializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dIn,
    input  logic             dEnable,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    // Shifted value includes the current dIn, so a completed word is available on the sampling edge.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shifted[gi] = dIn;
                end else begin : g_mv
                    assign shifted[gi] = sr_q[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign shifted[gi] = dIn;
                end else begin : g_mv
                    assign shifted[gi] = sr_q[gi+1];
                end
            end
        end
    endgenerate

    assign complete = dEnable && (cnt_q == CNT_LAST);

    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (dEnable) begin
            sr_d  = shifted;
            cnt_d = complete ? '0 : cnt_q + CNT_W'(1);
        end

        if (complete) begin
            // A same-edge ack frees the output register for the new word.
            if (!valid_q || ack) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign q       = word_q;
    assign valid   = valid_q;
    assign busy    = (cnt_q != '0);
    assign overrun = overrun_q;
endmodule

// File: tb/tb_dffe_word_deserializer.sv
// Bench for dffe_word_deserializer: directed vector table on an MSB-first instance,
// hand sequences for the LSB-first instance, then random traffic against a queue-based model.
module tb_dffe_word_deserializer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         din = 1'b0;
    logic         den = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] q_m, q_l;
    logic         valid_m, busy_m, ovr_m;
    logic         valid_l, busy_l, ovr_l;

    int checks = 0;
    int errors = 0;
    int txn = 0;

    always #5 clk = ~clk;

    dffe_word_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .dIn(din), .dEnable(den), .ack(ack),
        .q(q_m), .valid(valid_m), .busy(busy_m), .overrun(ovr_m)
    );

    dffe_word_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .dIn(din), .dEnable(den), .ack(ack),
        .q(q_l), .valid(valid_l), .busy(busy_l), .overrun(ovr_l)
    );

    // Reference model: received bits kept in a queue, word built by weighting bit positions.
    bit           m_bits[$];
    logic [W-1:0] m_q_msb = '0;
    logic [W-1:0] m_q_lsb = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;

    task automatic model_step(input logic r, input logic d, input logic e, input logic a);
        int wa, wb;
        bit done;
        if (r) begin
            m_bits.delete();
            m_q_msb = '0;
            m_q_lsb = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            done = 1'b0;
            if (e) begin
                m_bits.push_back(d);
                if (m_bits.size() == W) done = 1'b1;
            end
            if (done) begin
                wa = 0;
                wb = 0;
                for (int i = 0; i < W; i++) begin
                    wa = wa + (int'(m_bits[i]) * (1 << (W - 1 - i)));
                    wb = wb + (int'(m_bits[i]) * (1 << i));
                end
                m_bits.delete();
                if (!m_valid || a) begin
                    m_q_msb = W'(wa);
                    m_q_lsb = W'(wb);
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && a) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn=%0d got=%h expected=%h", name, txn, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic step(input logic r, input logic d, input logic e, input logic a);
        reset = r; din = d; den = e; ack = a;
        @(posedge clk);
        #1;
        model_step(r, d, e, a);
        txn++;
        $display("txn %0d: rst=%b en=%b d=%b ack=%b | msb q=%b v=%b b=%b o=%b | lsb q=%b v=%b",
                 txn, r, e, d, a, q_m, valid_m, busy_m, ovr_m, q_l, valid_l);
    endtask

    typedef struct {
        logic         r, d, e, a;
        logic [W-1:0] q;
        logic         v, b, o;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic d, input logic e, input logic a,
                       input logic [W-1:0] eq, input logic ev, input logic eb, input logic eo);
        vec_t t;
        t.r = r; t.d = d; t.e = e; t.a = a;
        t.q = eq; t.v = ev; t.b = eb; t.o = eo;
        tbl.push_back(t);
    endtask

    initial begin
        // Basic word 1,0,1,1
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 1, 1, 0, 4'b0000, 0, 1, 0);
        add(0, 0, 1, 0, 4'b0000, 0, 1, 0);
        add(0, 1, 1, 0, 4'b0000, 0, 1, 0);
        add(0, 1, 1, 0, 4'b1011, 1, 0, 0);
        // Overrun: 0,1,1,0 without ack
        add(0, 0, 1, 0, 4'b1011, 1, 1, 0);
        add(0, 1, 1, 0, 4'b1011, 1, 1, 0);
        add(0, 1, 1, 0, 4'b1011, 1, 1, 0);
        add(0, 0, 1, 0, 4'b1011, 1, 0, 1);
        add(0, 0, 0, 1, 4'b1011, 0, 0, 1);
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0);
        // ack while not valid is ignored
        add(0, 0, 0, 1, 4'b0000, 0, 0, 0);
        // Gapped enable 1,0,1,1
        add(0, 1, 1, 0, 4'b0000, 0, 1, 0);
        add(0, 0, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 0, 1, 0, 4'b0000, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 1, 1, 0, 4'b0000, 0, 1, 0);
        add(0, 0, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 0, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 0, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 1, 1, 0, 4'b1011, 1, 0, 0);
        // Completion + ack on the same edge: 0,1,0,1
        add(0, 0, 1, 0, 4'b1011, 1, 1, 0);
        add(0, 1, 1, 0, 4'b1011, 1, 1, 0);
        add(0, 0, 1, 0, 4'b1011, 1, 1, 0);
        add(0, 1, 1, 1, 4'b0101, 1, 0, 0);
        // Reset mid-word, then 0,0,1,0
        add(0, 1, 1, 0, 4'b0101, 1, 1, 0);
        add(0, 1, 1, 0, 4'b0101, 1, 1, 0);
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 0, 1, 0, 4'b0000, 0, 1, 0);
        add(0, 0, 1, 0, 4'b0000, 0, 1, 0);
        add(0, 1, 1, 0, 4'b0000, 0, 1, 0);
        add(0, 0, 1, 0, 4'b0010, 1, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].e, tbl[i].a);
            check("tbl_q", 16'(q_m), 16'(tbl[i].q));
            check("tbl_valid", 16'(valid_m), 16'(tbl[i].v));
            check("tbl_busy", 16'(busy_m), 16'(tbl[i].b));
            check("tbl_overrun", 16'(ovr_m), 16'(tbl[i].o));
        end

        // LSB-first ordering: stream 1,0,1,1 lands as 1101
        step(1, 0, 0, 0);
        check("lsb_reset_q", 16'(q_l), 16'h0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        check("lsb_busy", 16'(busy_l), 16'h1);
        step(0, 1, 1, 0);
        check("lsb_q", 16'(q_l), 16'b1101);
        check("lsb_valid", 16'(valid_l), 16'h1);
        check("lsb_busy_done", 16'(busy_l), 16'h0);
        check("msb_q_same_stream", 16'(q_m), 16'b1011);

        // Random traffic against the model, both bit orders
        for (int n = 0; n < 400; n++) begin
            logic r, d, e, a;
            r = ($urandom_range(0, 59) == 0);
            d = 1'($urandom);
            e = ($urandom_range(0, 9) < 6);
            a = ($urandom_range(0, 9) < 3);
            step(r, d, e, a);
            check("rnd_msb_q", 16'(q_m), 16'(m_q_msb));
            check("rnd_lsb_q", 16'(q_l), 16'(m_q_lsb));
            check("rnd_valid", 16'({valid_m, valid_l}), 16'({m_valid, m_valid}));
            check("rnd_busy", 16'({busy_m, busy_l}), 16'({2{m_bits.size() != 0}}));
            check("rnd_overrun", 16'({ovr_m, ovr_l}), 16'({m_ovr, m_ovr}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
